rng_axis_packer: RTL and testbench

- Upstream feeder for sample_dac1.
- Collects 32-bit random words from the RNG source and packs four of them into one 128-bit AXI-stream beat.
- Buffers the beats in a small FIFO and presents them on the s_axis_* input of sample_dac1.
- Start of packing can be aligned to a PPS rising edge, so DAC1 random patterns begin on a known second boundary.

---
 rtl/rng_axis_packer_pkg.sv | 25 ++
 rtl/rng_axis_packer_if.sv | 12 +
 rtl/rng_axis_packer_fifo.sv | 68 ++++++
 rtl/rng_axis_packer.sv | 169 ++++++++++++++++
 tb/tb_rng_axis_packer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rng_axis_packer_pkg.sv
// Shared definitions for the RNG-to-AXIS packer: default geometry, FSM state
// encoding and the saturating drop-counter helper.
package rng_pack_pkg;

  localparam int DEF_IN_W       = 32;
  localparam int DEF_OUT_W      = 128;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int WORDS_PER_BEAT = DEF_OUT_W / DEF_IN_W;
  localparam int FIFO_AW        = $clog2(DEF_FIFO_DEPTH);

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } pack_state_e;

  function automatic logic [15:0] drop_cnt_inc(input logic [15:0] cnt);
    return (cnt == DROP_CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/rng_axis_packer_if.sv
// Minimal AXI-stream bundle (data/valid/ready) used for both the RNG input
// and the packed-beat output of rng_axis_packer.
interface rng_axis_packer_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/rng_axis_packer_fifo.sv
// Synchronous beat FIFO with registered full/empty flags; the head entry is
// presented combinationally and reads as zero while the FIFO is empty.
module rng_pack_fifo
  import rng_pack_pkg::*;
#(
  parameter int W     = DEF_OUT_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic [AW:0]   w_count_nxt;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = push_i && !r_full;
  assign w_rd = pop_i && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW + 1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW + 1)'(DEPTH));
      r_empty <= (w_count_nxt == {(AW + 1){1'b0}});
    end
  end

  // Storage is left unreset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign head_o  = r_empty ? {W{1'b0}} : r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

// File: rtl/rng_axis_packer.sv
// Packs IN_W-bit RNG words into OUT_W-bit AXI-stream beats, optionally starting
// on a PPS rising edge. Optional beat counter: define RNG_PACK_BEAT_CNT_EN.
module rng_axis_packer
  import rng_pack_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_IN_W * WORDS_PER_BEAT,
  parameter int FIFO_DEPTH = 2 ** FIFO_AW
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_tresetn,
  input  logic                    en_i,
  input  logic                    pps_align_i,
  input  logic                    pps_i,
  input  logic                    clr_i,
  rng_axis_packer_if.slave        rng,
  rng_axis_packer_if.master       m_axis,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o
`ifdef RNG_PACK_BEAT_CNT_EN
  ,
  output logic [31:0]             beat_cnt_o
`endif
);

  localparam int WPB   = OUT_W / IN_W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  pack_state_e      r_state;
  pack_state_e      w_state_nxt;
  logic             r_pps_q;
  logic [IDX_W-1:0] r_word_idx;
  logic [OUT_W-1:0] r_beat;
  logic             r_overflow;
  logic [15:0]      r_drop_cnt;

  logic             w_pps_rise;
  logic             w_run;
  logic             w_run_entry;
  logic             w_rng_tready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [OUT_W-1:0] w_push_data;
  logic [OUT_W-1:0] w_head;

  assign w_pps_rise = pps_i & ~r_pps_q;

  // FSM state register
  always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
    if (!s_axis_tresetn) r_state <= ST_IDLE;
    else                 r_state <= w_state_nxt;
  end

  // FSM next-state logic; en_i is not looked at in DRAIN so a re-enable waits for IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en_i) w_state_nxt = pps_align_i ? ST_ARM : ST_RUN;
        else      w_state_nxt = ST_IDLE;
      end
      ST_ARM: begin
        if (!en_i)          w_state_nxt = ST_IDLE;
        else if (w_pps_rise) w_state_nxt = ST_RUN;
        else                w_state_nxt = ST_ARM;
      end
      ST_RUN: begin
        if (!en_i) w_state_nxt = ST_DRAIN;
        else       w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_fifo_empty) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; ready only looks at the registered full flag
  always_comb begin
    w_run        = (r_state == ST_RUN);
    w_run_entry  = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
    w_rng_tready = w_run && !((r_word_idx == LAST_IDX) && w_fifo_full);
  end

  assign w_accept = rng.tvalid && w_rng_tready;
  assign w_push   = w_accept && (r_word_idx == LAST_IDX);
  assign w_drop   = w_run && rng.tvalid && !w_rng_tready;
  assign w_pop    = !w_fifo_empty && m_axis.tready;

  // Completed beat: stored lanes plus the word arriving in the last lane
  always_comb begin
    w_push_data = r_beat;
    w_push_data[(WPB - 1) * IN_W +: IN_W] = rng.tdata;
  end

  // PPS edge detector, lane assembly and lane index
  always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
    if (!s_axis_tresetn) begin
      r_pps_q    <= 1'b0;
      r_word_idx <= {IDX_W{1'b0}};
      r_beat     <= {OUT_W{1'b0}};
    end else begin
      r_pps_q <= pps_i;
      if (!w_run) begin
        r_word_idx <= {IDX_W{1'b0}};
      end else if (w_accept) begin
        r_beat[r_word_idx * IN_W +: IN_W] <= rng.tdata;
        r_word_idx <= (r_word_idx == LAST_IDX) ? {IDX_W{1'b0}} : r_word_idx + 1'b1;
      end
    end
  end

  // Drop accounting; a clear in the same cycle as a drop wins
  always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
    if (!s_axis_tresetn) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (clr_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= drop_cnt_inc(r_drop_cnt);
    end
  end

  rng_pack_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (s_axis_clk),
    .rst_n       (s_axis_tresetn),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  assign rng.tready    = w_rng_tready;
  assign m_axis.tdata  = w_head;
  assign m_axis.tvalid = !w_fifo_empty;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;

`ifdef RNG_PACK_BEAT_CNT_EN
  logic [31:0] r_beat_cnt;

  // Popped-beat counter, restarted whenever a new packing run begins
  always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
    if (!s_axis_tresetn)            r_beat_cnt <= 32'd0;
    else if (clr_i || w_run_entry) r_beat_cnt <= 32'd0;
    else if (w_pop)                r_beat_cnt <= r_beat_cnt + 32'd1;
  end

  assign beat_cnt_o = r_beat_cnt;
`else
  logic w_unused;
  assign w_unused = w_run_entry;
`endif

endmodule

// File: tb/tb_rng_axis_packer.sv
// Randomized self-checking bench for rng_axis_packer against a queue-based
// reference model, plus directed scenarios for the documented corner cases.
module tb_rng_axis_packer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 128;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        align;
  logic        pps;
  logic        clr;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef RNG_PACK_BEAT_CNT_EN
  logic [31:0] beat_cnt;
`endif

  rng_axis_packer_if #(.W(IN_W))  rng_bus ();
  rng_axis_packer_if #(.W(OUT_W)) m_bus ();

  always #5 clk = ~clk;

  rng_axis_packer dut (
    .s_axis_clk     (clk),
    .s_axis_tresetn (rst_n),
    .en_i           (en),
    .pps_align_i    (align),
    .pps_i          (pps),
    .clr_i          (clr),
    .rng            (rng_bus),
    .m_axis         (m_bus),
    .overflow_o     (overflow),
    .drop_cnt_o     (drop_cnt)
`ifdef RNG_PACK_BEAT_CNT_EN
    ,
    .beat_cnt_o     (beat_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef enum {MD_OFF, MD_WAIT_PPS, MD_PACKING, MD_FLUSHING} mode_t;
  mode_t        m_mode;
  logic [31:0]  m_words[$];
  logic [127:0] m_beats[$];
  bit           m_ovf;
  int           m_drops;
  bit           m_pps_q;
  logic [31:0]  m_beat_cnt;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MD_OFF;
    m_words.delete();
    m_beats.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    m_pps_q = 1'b0;
    m_beat_cnt = 32'd0;
  endtask

  function automatic bit model_ready();
    return (m_mode == MD_PACKING) && !(m_words.size() == 3 && m_beats.size() == DEPTH);
  endfunction

  task automatic compare_outputs();
    logic [127:0] head;
    if (m_beats.size() != 0) head = m_beats[0];
    else                     head = 128'd0;
    check_val("rng_tready", rng_bus.tready, model_ready());
    check_val("m_tvalid", m_bus.tvalid, m_beats.size() != 0);
    check_val("m_tdata", m_bus.tdata, head);
    check_val("overflow", overflow, m_ovf);
    check_val("drop_cnt", drop_cnt, 128'(m_drops));
`ifdef RNG_PACK_BEAT_CNT_EN
    check_val("beat_cnt", beat_cnt, m_beat_cnt);
`endif
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    bit rdy, pop, acc, drop, rise, was_empty, enter;
    rdy       = model_ready();
    was_empty = (m_beats.size() == 0);
    pop       = !was_empty && m_bus.tready;
    acc       = rng_bus.tvalid && rdy;
    drop      = (m_mode == MD_PACKING) && rng_bus.tvalid && !rdy;
    rise      = pps && !m_pps_q;
    m_pps_q   = pps;
    enter     = 1'b0;
    if (pop) void'(m_beats.pop_front());
    if (acc) begin
      m_words.push_back(rng_bus.tdata);
      if (m_words.size() == 4) begin
        m_beats.push_back({m_words[3], m_words[2], m_words[1], m_words[0]});
        m_words.delete();
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    case (m_mode)
      MD_OFF: if (en) begin
        if (align) m_mode = MD_WAIT_PPS;
        else begin m_mode = MD_PACKING; enter = 1'b1; end
      end
      MD_WAIT_PPS: begin
        if (!en) m_mode = MD_OFF;
        else if (rise) begin m_mode = MD_PACKING; enter = 1'b1; end
      end
      MD_PACKING: if (!en) m_mode = MD_FLUSHING;
      MD_FLUSHING: begin
        m_words.delete();
        if (was_empty) m_mode = MD_OFF;
      end
      default: m_mode = MD_OFF;
    endcase
    if (clr || enter) m_beat_cnt = 32'd0;
    else if (pop)     m_beat_cnt = m_beat_cnt + 32'd1;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en_v, input logic align_v, input logic pps_v, input logic clr_v,
                       input logic tv, input logic [31:0] td, input logic mrdy);
    en = en_v; align = align_v; pps = pps_v; clr = clr_v;
    rng_bus.tvalid = tv; rng_bus.tdata = td; m_bus.tready = mrdy;
  endtask

  initial begin
    logic [31:0] w4 [4];
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_tready", rng_bus.tready, 1'b0);
    check_val("rst_tvalid", m_bus.tvalid, 1'b0);
    check_val("rst_tdata", m_bus.tdata, 128'd0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_drop_cnt", drop_cnt, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic packing without PPS alignment
    w4[0] = 32'h44444444; w4[1] = 32'h33333333; w4[2] = 32'h22222222; w4[3] = 32'h12341111;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w4[i], 1'b1);
      cycle();
      if (i == 2) check_val("beat0_early", m_bus.tvalid, 1'b0);
    end
    check_val("beat0_valid", m_bus.tvalid, 1'b1);
    check_val("beat0_data", m_bus.tdata, 128'h12341111_22222222_33333333_44444444);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle();

    // Backpressure: fill the FIFO, then four drops
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    cycle();
    for (int i = 0; i < 23; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      cycle();
    end
    check_val("bp_drops", drop_cnt, 16'd4);
    check_val("bp_overflow", overflow, 1'b1);
    check_val("bp_tready", rng_bus.tready, 1'b0);

    // Clear coinciding with a drop
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, $urandom, 1'b0);
    cycle();
    check_val("clr_overflow", overflow, 1'b0);
    check_val("clr_drop_cnt", drop_cnt, 16'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle();
    end

    // Disable after six words with one beat queued
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      cycle();
    end
    check_val("drain_holds", m_bus.tvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle();
    end
    check_val("drain_empty", m_bus.tvalid, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b1);
      cycle();
    end
    check_val("lane0_restart", m_bus.tdata, 128'h000000A3_000000A2_000000A1_000000A0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle();
    end

    // PPS-aligned start with words offered continuously
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, 1'b1, (c == 99), 1'b0, 1'b1, $urandom, 1'b1);
      cycle();
      if (c < 99) check_val("arm_tready", rng_bus.tready, 1'b0);
    end
    check_val("pps_first_accept", rng_bus.tready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 1'b1);
      cycle();
    end
    check_val("pps_overflow", overflow, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic en_v;
      en_v = ($urandom_range(0, 99) < 3) ? !en : en;
      drive(en_v, 1'($urandom_range(0, 1)), ($urandom_range(0, 22) == 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            $urandom, ($urandom_range(0, 2) != 0));
      cycle();
    end

    // Async reset in the middle of a burst
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      cycle();
    end
    check_val("burst_tvalid", m_bus.tvalid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_tready", rng_bus.tready, 1'b0);
    check_val("arst_tvalid", m_bus.tvalid, 1'b0);
    check_val("arst_tdata", m_bus.tdata, 128'd0);
    check_val("arst_overflow", overflow, 1'b0);
    check_val("arst_drop_cnt", drop_cnt, 16'd0);
`ifdef RNG_PACK_BEAT_CNT_EN
    check_val("arst_beat_cnt", beat_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
